// File: rtl/pes_secded_pkg.sv
// Shared SECDED definitions: widths, pipeline beat layouts and the 16-bit
// extended-Hamming encoder, reused by the matching decoder.
package pes_secded_pkg;

    localparam int DW   = 16;
    localparam int CW   = 22;
    localparam int NPAR = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          cout;
        logic          inj_en;
        logic [4:0]    inj_pos;
    } s1_beat_t;

    typedef struct packed {
        logic [CW-1:0] code;
        logic          cout;
    } s2_beat_t;

    // Hamming position of data bit idx: the non-power-of-two slots 3..21.
    function automatic logic [4:0] data_pos(input logic [3:0] idx);
        logic [4:0] pos;
        case (idx)
            4'd0:    pos = 5'd3;
            4'd1:    pos = 5'd5;
            4'd2:    pos = 5'd6;
            4'd3:    pos = 5'd7;
            4'd4:    pos = 5'd9;
            4'd5:    pos = 5'd10;
            4'd6:    pos = 5'd11;
            4'd7:    pos = 5'd12;
            4'd8:    pos = 5'd13;
            4'd9:    pos = 5'd14;
            4'd10:   pos = 5'd15;
            4'd11:   pos = 5'd17;
            4'd12:   pos = 5'd18;
            4'd13:   pos = 5'd19;
            4'd14:   pos = 5'd20;
            4'd15:   pos = 5'd21;
            default: pos = 5'd3;
        endcase
        return pos;
    endfunction

    function automatic logic [CW-1:0] secded_encode(input logic [DW-1:0] data);
        logic [CW-1:0] code;
        logic          par;
        code = '0;
        for (int i = 0; i < DW; i++) begin
            code[data_pos(4'(i))] = data[i];
        end
        // Parity slot 2^k is still zero while p_k is summed, so it needs no exclusion.
        for (int k = 0; k < NPAR; k++) begin
            par = 1'b0;
            for (int j = 1; j < CW; j++) begin
                if (j[k]) begin
                    par = par ^ code[j];
                end
            end
            code[1 << k] = par;
        end
        code[0] = ^code[CW-1:1];
        return code;
    endfunction

endpackage

// File: rtl/pes_pipe_reg.sv
// Single valid/ready register slice; accepts whenever empty or draining.
module pes_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Slice register: load on advance, data held otherwise so stalls stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/pes_secded_enc.sv
// Two-stage SECDED encoder behind the adder: S1 captures the raw beat, S2
// holds the encoded codeword with any injected bit flip applied.
module pes_secded_enc #(
    parameter int DW = 16,
    parameter int CW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_cout,
    input  logic          inj_en,
    input  logic [4:0]    inj_pos,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_code,
    output logic          out_cout,
    output logic [15:0]   enc_count
);

    import pes_secded_pkg::*;

    if (DW != pes_secded_pkg::DW || CW != pes_secded_pkg::CW) begin : g_param_check
        $error("pes_secded_enc: DW must be 16 and CW must be 22");
    end

    s1_beat_t s1_in_s;
    s1_beat_t s1_q;
    s2_beat_t s2_in_s;
    s2_beat_t s2_q;
    logic     s1_valid_s;
    logic     s2_ready_s;
    logic [pes_secded_pkg::CW-1:0] flip_mask_s;
    logic [15:0] count_q;
    logic [15:0] count_d;

    assign s1_in_s = '{data: in_data, cout: in_cout, inj_en: inj_en, inj_pos: inj_pos};

    pes_pipe_reg #(.W($bits(s1_beat_t))) u_s1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (s1_in_s),
        .out_valid_o (s1_valid_s),
        .out_ready_i (s2_ready_s),
        .out_data_o  (s1_q)
    );

    // Injection mask; positions 22..31 leave the codeword untouched.
    always_comb begin
        flip_mask_s = '0;
        if (s1_q.inj_en && (s1_q.inj_pos <= 5'd21)) begin
            flip_mask_s = 22'd1 << s1_q.inj_pos;
        end else begin
            flip_mask_s = '0;
        end
    end

    assign s2_in_s = '{code: secded_encode(s1_q.data) ^ flip_mask_s, cout: s1_q.cout};

    pes_pipe_reg #(.W($bits(s2_beat_t))) u_s2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (s1_valid_s),
        .in_ready_o  (s2_ready_s),
        .in_data_i   (s2_in_s),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s2_q)
    );

    assign out_code  = s2_q.code;
    assign out_cout  = s2_q.cout;
    assign enc_count = count_q;

    // Next transfer count; wraps silently.
    always_comb begin
        count_d = count_q;
        if (out_valid && out_ready) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pes_secded_enc.sv
// Directed bench for pes_secded_enc: table of hand-encoded beats plus stall,
// async-reset and counter-wrap sequences.
module tb_pes_secded_enc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_cout;
    logic        inj_en;
    logic [4:0]  inj_pos;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] out_code;
    logic        out_cout;
    logic [15:0] enc_count;

    int total;
    int bad;

    typedef struct {
        logic [15:0] data;
        logic        cout;
        logic        inj_en;
        logic [4:0]  inj_pos;
        logic [21:0] code;
    } vec_t;

    vec_t vecs[13];

    pes_secded_enc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cout   (in_cout),
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_cout  (out_cout),
        .enc_count (enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_beat(input logic [15:0] d, input logic c, input logic ie, input logic [4:0] ip);
        in_data  = d;
        in_cout  = c;
        inj_en   = ie;
        inj_pos  = ip;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{16'h0000, 1'b0, 1'b0, 5'd0,  22'h000000};
        vecs[1]  = '{16'h0001, 1'b0, 1'b0, 5'd0,  22'h00000F};
        vecs[2]  = '{16'hFFFF, 1'b1, 1'b0, 5'd0,  22'h3FFFFC};
        vecs[3]  = '{16'h1234, 1'b0, 1'b0, 5'd0,  22'h054742};
        vecs[4]  = '{16'hABCD, 1'b1, 1'b0, 5'd0,  22'h2B78CA};
        vecs[5]  = '{16'h8000, 1'b0, 1'b0, 5'd0,  22'h210012};
        vecs[6]  = '{16'h0001, 1'b0, 1'b1, 5'd3,  22'h000007};
        vecs[7]  = '{16'h0001, 1'b0, 1'b1, 5'd25, 22'h00000F};
        vecs[8]  = '{16'h0001, 1'b0, 1'b1, 5'd0,  22'h00000E};
        vecs[9]  = '{16'h0001, 1'b0, 1'b1, 5'd21, 22'h20000F};
        vecs[10] = '{16'h0001, 1'b0, 1'b1, 5'd22, 22'h00000F};
        vecs[11] = '{16'h1234, 1'b1, 1'b1, 5'd18, 22'h014742};
        vecs[12] = '{16'hFFFF, 1'b0, 1'b0, 5'd3,  22'h3FFFFC};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_beat(16'h0000, 1'b0, 1'b0, 5'd0);
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_code",  32'(out_code),  32'd0);
        check("reset_out_cout",  32'(out_cout),  32'd0);
        check("reset_enc_count", 32'(enc_count), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;

        // Table: one beat at a time with the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            set_beat(vecs[i].data, vecs[i].cout, vecs[i].inj_en, vecs[i].inj_pos);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            set_beat(16'h5A5A, 1'b0, 1'b1, 5'd1);
            check($sformatf("vec%0d_not_early", i), 32'(out_valid), 32'd0);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_code", i),  32'(out_code),  32'(vecs[i].code));
            check($sformatf("vec%0d_cout", i),  32'(out_cout),  32'(vecs[i].cout));
            tick();
            check($sformatf("vec%0d_count", i), 32'(enc_count), 32'(i + 1));
        end

        // Back-to-back beats with the sink stalled for three edges.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_beat(16'h1234, 1'b0, 1'b0, 5'd0);
        check("stall_rdy0", 32'(in_ready), 32'd1);
        tick();
        set_beat(16'hABCD, 1'b1, 1'b0, 5'd0);
        check("stall_rdy1", 32'(in_ready), 32'd1);
        tick();
        set_beat(16'h0001, 1'b0, 1'b0, 5'd0);
        check("stall_rdy_full", 32'(in_ready), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_code0", 32'(out_code), 32'h054742);
        tick();
        check("stall_hold1", 32'(out_code), 32'h054742);
        check("stall_rdy_hold1", 32'(in_ready), 32'd0);
        tick();
        check("stall_hold2", 32'(out_code), 32'h054742);
        check("stall_cnt_hold", 32'(enc_count), 32'd0);
        out_ready = 1'b1;
        #1;
        check("stall_rdy_release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("drain_code1", 32'(out_code), 32'h2B78CA);
        check("drain_cout1", 32'(out_cout), 32'd1);
        check("drain_cnt1", 32'(enc_count), 32'd1);
        tick();
        check("drain_code2", 32'(out_code), 32'h00000F);
        check("drain_cout2", 32'(out_cout), 32'd0);
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_cnt3", 32'(enc_count), 32'd3);

        // Asynchronous reset with two beats in flight.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_beat(16'h0001, 1'b0, 1'b0, 5'd0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_beat(16'h1234, 1'b0, 1'b0, 5'd0);
        tick();
        set_beat(16'hABCD, 1'b1, 1'b0, 5'd0);
        tick();
        in_valid = 1'b0;
        check("arst_pre_valid", 32'(out_valid), 32'd1);
        check("arst_pre_cnt", 32'(enc_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_cnt", 32'(enc_count), 32'd0);
        check("arst_code", 32'(out_code), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_beat(16'hFFFF, 1'b1, 1'b0, 5'd0);
        tick();
        in_valid = 1'b0;
        check("arst_lat1", 32'(out_valid), 32'd0);
        tick();
        check("arst_lat2", 32'(out_valid), 32'd1);
        check("arst_code_new", 32'(out_code), 32'h3FFFFC);
        check("arst_cout_new", 32'(out_cout), 32'd1);
        tick();
        check("arst_cnt_new", 32'(enc_count), 32'd1);

        // Counter wrap: 0xFFFF streamed transfers, then one more.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            set_beat(16'(i), 1'b0, 1'b0, 5'd0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("wrap_ffff", 32'(enc_count), 32'h0000FFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("wrap_zero", 32'(enc_count), 32'd0);
        check("wrap_empty", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
